load_store_unit: RTL and testbench

//  Segmented memory load/store engine between the microcode datapath and the 16-bit memory bus.
//  - Computes the physical address as (segment << SEG_SHIFT) + mar.
//  - Performs byte or word reads and writes.
//  - Splits odd-addressed word accesses into two bus cycles.
//  - Holds MAR/MDR for the execution core.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Segmented memory load/store engine between the microcode datapath and the 16-bit bus.
// Optional bus watchdog (abort + bus_error) is built when LSU_BUS_TIMEOUT_EN is defined.
module load_store_unit #(
    parameter int ADDR_W    = 20,
    parameter int SEG_SHIFT = 4
`ifdef LSU_BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_mar,
    input  logic [15:0]       mar_in,
    input  logic [15:0]       segment,
    input  logic              write_mdr,
    input  logic [15:0]       mdr_in,
    output logic [15:0]       mdr_out,
    input  logic              is_8bit,
    input  logic              wr_en,
    input  logic              start,
    output logic              busy,
    output logic              complete,
    output logic [ADDR_W-2:0] m_addr,
    input  logic [15:0]       m_data_in,
    output logic [15:0]       m_data_out,
    output logic              m_access,
    input  logic              m_ack,
    output logic              m_wr_en,
    output logic [1:0]        m_bytesel
`ifdef LSU_BUS_TIMEOUT_EN
    ,
    output logic              bus_error
`endif
);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

    state_t      state;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] seg_q;
    logic [15:0] off_q;
    logic [7:0]  hi_q;
    logic        byte_q;
    logic        wr_q;
    logic        split_q;

    // Physical byte address wraps at ADDR_W bits; the bus sees the word address.
    function automatic logic [ADDR_W-2:0] word_addr(input logic [15:0] seg, input logic [15:0] off);
        return (ADDR_W-1)'(((ADDR_W'(seg) << SEG_SHIFT) + ADDR_W'(off)) >> 1);
    endfunction

    logic              aligned_word;
    logic [ADDR_W-2:0] first_addr;
    logic [ADDR_W-2:0] second_addr;
    logic [1:0]        first_sel;
    logic [15:0]       first_dout;
    logic [15:0]       second_dout;
    logic [15:0]       first_load;
    logic              ack;
    logic              advance;
    logic              finish;
    logic              abort;

    assign mdr_out      = mdr;
    assign aligned_word = ~is_8bit & ~mar[0];
    assign first_addr   = word_addr(segment, mar);
    // Offset wraps within 16 bits, so the second half stays in the same segment.
    assign second_addr  = word_addr(seg_q, off_q + 16'd1);
    assign first_sel    = aligned_word ? 2'b11 : (mar[0] ? 2'b10 : 2'b01);
    assign first_dout   = !wr_en       ? 16'h0000 :
                          aligned_word ? mdr :
                          mar[0]       ? {mdr[7:0], 8'h00} : {8'h00, mdr[7:0]};
    assign second_dout  = wr_q ? {8'h00, hi_q} : 16'h0000;
    // Split first half and odd byte both take the high lane into mdr[7:0].
    assign first_load   = (~byte_q & ~off_q[0]) ? m_data_in :
                          off_q[0]              ? {8'h00, m_data_in[15:8]} : {8'h00, m_data_in[7:0]};

    assign ack     = m_access & m_ack;
    assign advance = ack & (state == FIRST) & split_q;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign abort = ~ack & ((state == FIRST) | (state == SECOND)) &
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    assign finish = (ack & ~advance) | abort;

    // NOTE: every register in this block uses non-blocking assignment so that all
    // right-hand sides see pre-edge values; blocking here would create order-dependent state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mar        <= 16'h0000;
            mdr        <= 16'h0000;
            seg_q      <= 16'h0000;
            off_q      <= 16'h0000;
            hi_q       <= 8'h00;
            byte_q     <= 1'b0;
            wr_q       <= 1'b0;
            split_q    <= 1'b0;
            busy       <= 1'b0;
            complete   <= 1'b0;
            m_addr     <= '0;
            m_data_out <= 16'h0000;
            m_access   <= 1'b0;
            m_wr_en    <= 1'b0;
            m_bytesel  <= 2'b00;
`ifdef LSU_BUS_TIMEOUT_EN
            wait_cnt   <= '0;
            bus_error  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (write_mar) mar <= mar_in;
                    if (write_mdr) mdr <= mdr_in;
                    if (start) begin
                        // The access captures the pre-edge mar/mdr even if they are written now.
                        seg_q      <= segment;
                        off_q      <= mar;
                        hi_q       <= mdr[15:8];
                        byte_q     <= is_8bit;
                        wr_q       <= wr_en;
                        split_q    <= mar[0] & ~is_8bit;
                        if (!wr_en) mdr <= 16'h0000;
                        m_addr     <= first_addr;
                        m_bytesel  <= first_sel;
                        m_data_out <= first_dout;
                        m_wr_en    <= wr_en;
                        m_access   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FIRST;
`ifdef LSU_BUS_TIMEOUT_EN
                        wait_cnt   <= '0;
                        bus_error  <= 1'b0;
`endif
                    end
                end

                FIRST, SECOND: begin
                    if (ack && !wr_q) begin
                        if (state == FIRST) mdr <= first_load;
                        else                mdr[15:8] <= m_data_in[7:0];
                    end
                    if (advance) begin
                        state      <= SECOND;
                        m_addr     <= second_addr;
                        m_bytesel  <= 2'b01;
                        m_data_out <= second_dout;
                    end
                    if (finish) begin
                        state      <= DONE;
                        complete   <= 1'b1;
                        m_access   <= 1'b0;
                        m_wr_en    <= 1'b0;
                        m_bytesel  <= 2'b00;
                        m_data_out <= 16'h0000;
                    end
`ifdef LSU_BUS_TIMEOUT_EN
                    if (ack || abort) wait_cnt <= '0;
                    else              wait_cnt <= wait_cnt + 1'b1;
                    if (abort) begin
                        bus_error <= 1'b1;
                        if (!wr_q) mdr <= 16'hFFFF;
                    end
`endif
                end

                DONE: begin
                    complete <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus transfers and
// completions; a monitor pops and compares on each acked transfer and complete pulse.
`timescale 1ns/1ps
module tb_load_store_unit;

    typedef struct {
        bit          done;
        logic [18:0] addr;
        logic [1:0]  sel;
        logic        wr;
        logic [15:0] dout;
        bit          chk_dout;
        logic [15:0] mdr;
        logic        err;
    } exp_t;

    typedef struct {
        int          waits;
        logic [15:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_mar;
    logic [15:0] mar_in;
    logic [15:0] segment;
    logic        write_mdr;
    logic [15:0] mdr_in;
    logic [15:0] mdr_out;
    logic        is_8bit;
    logic        wr_en;
    logic        start;
    logic        busy;
    logic        complete;
    logic [18:0] m_addr;
    logic [15:0] m_data_in = 16'h0000;
    logic [15:0] m_data_out;
    logic        m_access;
    logic        m_ack = 1'b0;
    logic        m_wr_en;
    logic [1:0]  m_bytesel;
`ifdef LSU_BUS_TIMEOUT_EN
    logic        bus_error;
`endif

    exp_t exp_q[$];
    rsp_t rsp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic mon_prev_complete = 1'b0;
    int   lat;
    int   n;

    load_store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .write_mar (write_mar),
        .mar_in    (mar_in),
        .segment   (segment),
        .write_mdr (write_mdr),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .is_8bit   (is_8bit),
        .wr_en     (wr_en),
        .start     (start),
        .busy      (busy),
        .complete  (complete),
        .m_addr    (m_addr),
        .m_data_in (m_data_in),
        .m_data_out(m_data_out),
        .m_access  (m_access),
        .m_ack     (m_ack),
        .m_wr_en   (m_wr_en),
        .m_bytesel (m_bytesel)
`ifdef LSU_BUS_TIMEOUT_EN
        ,.bus_error(bus_error)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_bus(input logic [18:0] addr, input logic [1:0] sel, input logic wr,
                            input logic [15:0] dout);
        exp_t e;
        e = '{done: 1'b0, addr: addr, sel: sel, wr: wr, dout: dout, chk_dout: wr,
              mdr: 16'h0000, err: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [15:0] mdr, input logic err);
        exp_t e;
        e = '{done: 1'b1, addr: 19'h0, sel: 2'b00, wr: 1'b0, dout: 16'h0000, chk_dout: 1'b0,
              mdr: mdr, err: err};
        exp_q.push_back(e);
    endtask

    task automatic push_rsp(input int waits, input logic [15:0] data);
        rsp_t r;
        r = '{waits: waits, data: data};
        rsp_q.push_back(r);
    endtask

    task automatic set_regs(input logic [15:0] mar_v, input logic [15:0] mdr_v);
        @(posedge clk); #1;
        write_mar = 1'b1; mar_in = mar_v;
        write_mdr = 1'b1; mdr_in = mdr_v;
        @(posedge clk); #1;
        write_mar = 1'b0; write_mdr = 1'b0;
    endtask

    // One access; cycles counts negedges from the start edge up to the complete pulse.
    task automatic run(input logic [15:0] seg, input logic b8, input logic wr, input logic wm,
                       input logic [15:0] wm_val, input logic poke, output int cycles);
        @(posedge clk); #1;
        segment = seg; is_8bit = b8; wr_en = wr; start = 1'b1;
        write_mar = wm; mar_in = wm_val;
        @(posedge clk); #1;
        start = 1'b0; write_mar = 1'b0;
        segment = 16'h5555; is_8bit = ~b8; wr_en = ~wr;
        cycles = 0;
        if (poke) begin
            start = 1'b1; write_mar = 1'b1; mar_in = 16'h1234;
            write_mdr = 1'b1; mdr_in = 16'hDEAD;
            @(posedge clk); #1;
            start = 1'b0; write_mar = 1'b0; write_mdr = 1'b0;
            cycles = 1;
        end
        while (complete !== 1'b1 && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        check("complete_seen", complete, 1'b1);
    endtask

    // Bus slave: acks each request after the queued number of wait cycles.
    initial begin
        int waitc;
        waitc = 0;
        forever begin
            @(posedge clk); #1;
            m_ack = 1'b0;
            if (m_access === 1'b1 && reset !== 1'b1 && rsp_q.size() > 0) begin
                if (waitc >= rsp_q[0].waits) begin
                    m_ack     = 1'b1;
                    m_data_in = rsp_q[0].data;
                    void'(rsp_q.pop_front());
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end else begin
                waitc = 0;
            end
        end
    end

    // Monitor: pops one expectation per acked transfer and per complete pulse.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (m_access === 1'b1 && m_ack === 1'b1) begin
                    ok = (exp_q.size() > 0) && !exp_q[0].done;
                    check("bus_transfer_expected", ok, 1'b1);
                    if (ok) begin
                        e = exp_q.pop_front();
                        check("m_addr", m_addr, e.addr);
                        check("m_bytesel", m_bytesel, e.sel);
                        check("m_wr_en", m_wr_en, e.wr);
                        if (e.chk_dout) check("m_data_out", m_data_out, e.dout);
                    end
                end
                if (complete === 1'b1) begin
                    check("complete_single_cycle", mon_prev_complete, 1'b0);
                    ok = (exp_q.size() > 0) && exp_q[0].done;
                    check("complete_expected", ok, 1'b1);
                    if (ok) begin
                        e = exp_q.pop_front();
                        check("mdr_out", mdr_out, e.mdr);
`ifdef LSU_BUS_TIMEOUT_EN
                        check("bus_error", bus_error, e.err);
`endif
                    end
                end
            end
            mon_prev_complete = complete;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; write_mar = 1'b0; mar_in = 16'h0; segment = 16'h0;
        write_mdr = 1'b0; mdr_in = 16'h0; is_8bit = 1'b0; wr_en = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_complete", complete, 1'b0);
        check("rst_m_access", m_access, 1'b0);
        check("rst_m_wr_en", m_wr_en, 1'b0);
        check("rst_m_bytesel", m_bytesel, 2'b00);
        check("rst_m_data_out", m_data_out, 16'h0000);
        check("rst_mdr", mdr_out, 16'h0000);
`ifdef LSU_BUS_TIMEOUT_EN
        check("rst_bus_error", bus_error, 1'b0);
`endif
        reset = 1'b0;

        // Aligned load, 2 wait cycles; writes and start while busy must be ignored.
        set_regs(16'h0010, 16'h0000);
        push_bus(19'h08008, 2'b11, 1'b0, 16'h0);
        push_rsp(2, 16'h5A3C);
        push_done(16'h5A3C, 1'b0);
        run(16'h1000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, lat);

        // Even byte load reusing mar (0x0010 survived the busy write); minimum latency.
        push_bus(19'h08008, 2'b01, 1'b0, 16'h0);
        push_rsp(0, 16'hBEEF);
        push_done(16'h00EF, 1'b0);
        run(16'h1000, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat);
        check("min_latency", lat, 2);

        // Split load at offset 3.
        set_regs(16'h0003, 16'h0000);
        push_bus(19'h00001, 2'b10, 1'b0, 16'h0);
        push_bus(19'h00002, 2'b01, 1'b0, 16'h0);
        push_rsp(1, 16'hAB12);
        push_rsp(0, 16'h34CD);
        push_done(16'hCDAB, 1'b0);
        run(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, lat);

        // Odd byte store.
        set_regs(16'h0005, 16'h0077);
        push_bus(19'h00002, 2'b10, 1'b1, 16'h7700);
        push_rsp(0, 16'h0000);
        push_done(16'h0077, 1'b0);
        run(16'h0000, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, lat);

        // Segment and offset wrap: bytes 0x0FFEF then 0xFFFF0.
        set_regs(16'hFFFF, 16'h0000);
        push_bus(19'h07FF7, 2'b10, 1'b0, 16'h0);
        push_bus(19'h7FFF8, 2'b01, 1'b0, 16'h0);
        push_rsp(0, 16'h1100);
        push_rsp(0, 16'h0022);
        push_done(16'h2211, 1'b0);
        run(16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, lat);

        // Aligned word store: byte 0x20 + 0x100 = 0x120.
        set_regs(16'h0100, 16'hC0DE);
        push_bus(19'h00090, 2'b11, 1'b1, 16'hC0DE);
        push_rsp(1, 16'h0000);
        push_done(16'hC0DE, 1'b0);
        run(16'h0002, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, lat);

        // Split word store at offset 7.
        set_regs(16'h0007, 16'hA1B2);
        push_bus(19'h00003, 2'b10, 1'b1, 16'hB200);
        push_bus(19'h00004, 2'b01, 1'b1, 16'h00A1);
        push_rsp(0, 16'h0000);
        push_rsp(2, 16'h0000);
        push_done(16'hA1B2, 1'b0);
        run(16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, lat);

        // Even byte store.
        set_regs(16'h0004, 16'h1234);
        push_bus(19'h00002, 2'b01, 1'b1, 16'h0034);
        push_rsp(0, 16'h0000);
        push_done(16'h1234, 1'b0);
        run(16'h0000, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, lat);

        // start with write_mar: access uses old mar (4), the new mar (0x100) applies next time.
        push_bus(19'h00002, 2'b01, 1'b0, 16'h0);
        push_rsp(0, 16'h9988);
        push_done(16'h0088, 1'b0);
        run(16'h0000, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, lat);
        push_bus(19'h00080, 2'b01, 1'b0, 16'h0);
        push_rsp(0, 16'h0055);
        push_done(16'h0055, 1'b0);
        run(16'h0000, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat);

        // Odd byte load.
        set_regs(16'h0101, 16'h0000);
        push_bus(19'h00080, 2'b10, 1'b0, 16'h0);
        push_rsp(0, 16'h66AA);
        push_done(16'h0066, 1'b0);
        run(16'h0000, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, lat);

        // Reset asserted while waiting in SECOND.
        set_regs(16'h0009, 16'h0000);
        push_bus(19'h00004, 2'b10, 1'b0, 16'h0);
        push_rsp(0, 16'h1111);
        @(posedge clk); #1;
        segment = 16'h0000; is_8bit = 1'b0; wr_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (m_bytesel !== 2'b01 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_second_lanes", m_bytesel, 2'b01);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_m_access", m_access, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_complete", complete, 1'b0);
        check("midrst_m_bytesel", m_bytesel, 2'b00);
        check("midrst_mdr", mdr_out, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // After reset mar = 0: aligned load at segment 3 -> byte 0x30.
        push_bus(19'h00018, 2'b11, 1'b0, 16'h0);
        push_rsp(0, 16'h7777);
        push_done(16'h7777, 1'b0);
        run(16'h0003, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, lat);
        check("post_reset_latency", lat, 2);

`ifdef LSU_BUS_TIMEOUT_EN
        // Load with no ack aborts with 0xFFFF and bus_error; the next start clears it.
        set_regs(16'h0010, 16'h0000);
        push_done(16'hFFFF, 1'b1);
        run(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, lat);
        check("timeout_latency", lat, 65);
        push_bus(19'h00008, 2'b11, 1'b0, 16'h0);
        push_rsp(0, 16'h4242);
        push_done(16'h4242, 1'b0);
        run(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, lat);
`endif

        repeat (5) @(posedge clk);
        check("pending_expectations", exp_q.size(), 0);
        check("unused_responses", rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
